mem_responder: RTL

- Responder end of the per-thread data-memory valid/ready interface that the load-store units drive.
- Accepts LDR/STR requests from NUM_CONSUMERS initiators and arbitrates between them round-robin.
- Services one request at a time against an internal word-addressed data memory, with a fixed configurable access latency.
- Returns read data and a single-cycle ready pulse per request. Sits between the cores' LSUs and data memory; also serves as the data-memory model in core-level benches.

---
 rtl/mem_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Responder end of the per-thread data-memory valid/ready interface.
// Round-robin arbitration across NUM_CONSUMERS initiators. One request at a
// time is serviced against an internal word-addressed memory with a fixed
// access latency. Each request ends with a single-cycle ready pulse.
module mem_responder #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int LATENCY       = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               busy
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  // Consumer 0 must win the first arbitration after reset.
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_CONSUMERS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic                 cap_rd_q, cap_rd_d;
  logic                 cap_wr_q, cap_wr_d;
  logic [ADDR_BITS-1:0] cap_raddr_q, cap_raddr_d;
  logic [ADDR_BITS-1:0] cap_waddr_q, cap_waddr_d;
  logic [DATA_BITS-1:0] cap_wdata_q, cap_wdata_d;

  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rd_data_d [NUM_CONSUMERS];

  logic [DATA_BITS-1:0]     mem [DEPTH];

  logic [ADDR_BITS-1:0]     rd_addr_arr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr_arr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data_arr [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0] eligible;
  logic                     grant_ok;
  logic [IDX_W-1:0]         winner;
  logic [IDX_W-1:0]         cand;
  logic                     complete;
  logic [DATA_BITS-1:0]     rd_word;

  // Unpack the flat per-consumer buses and pack the read-data registers back.
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_port
    assign rd_addr_arr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_arr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_arr[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  // A consumer whose ready is high this cycle drops valid on this edge, so it
  // must not be re-granted on the strength of that stale valid.
  assign eligible = (consumer_read_valid | consumer_write_valid)
                  & ~(rd_ready_q | wr_ready_q);

  assign complete = (state_q == ST_WAIT) && (cnt_q == '0);

  // Write-then-read ordering: a same-request write to the read address wins.
  assign rd_word = (cap_wr_q && (cap_waddr_q == cap_raddr_q)) ? cap_wdata_q
                                                              : mem[cap_raddr_q];

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign busy                 = (state_q != ST_IDLE);

  // Round-robin search starting one past the previous winner.
  always_comb begin
    grant_ok = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_CONSUMERS; off++) begin
      cand = IDX_W'((int'(last_grant_q) + off) % NUM_CONSUMERS);
      if (!grant_ok && eligible[cand]) begin
        grant_ok = 1'b1;
        winner   = cand;
      end
    end
  end

  // Next-state logic: IDLE -> WAIT (grant), WAIT counts down, RESPOND pulses
  // ready and may grant the next request back-to-back.
  always_comb begin
    // NOTE: every _d signal gets a default first so no branch can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cur_d        = cur_q;
    cap_rd_d     = cap_rd_q;
    cap_wr_d     = cap_wr_q;
    cap_raddr_d  = cap_raddr_q;
    cap_waddr_d  = cap_waddr_q;
    cap_wdata_d  = cap_wdata_q;
    rd_ready_d   = '0;
    wr_ready_d   = '0;
    rd_data_d    = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d           = ST_RESPOND;
          rd_ready_d[cur_q] = cap_rd_q;
          wr_ready_d[cur_q] = cap_wr_q;
          if (cap_rd_q) rd_data_d[cur_q] = rd_word;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = grant_ok ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant edge: snapshot the winner's request so later input changes
    // (including withdrawal) cannot disturb it.
    if (grant_ok && (state_q != ST_WAIT)) begin
      last_grant_d = winner;
      cur_d        = winner;
      cap_rd_d     = consumer_read_valid[winner];
      cap_wr_d     = consumer_write_valid[winner];
      cap_raddr_d  = rd_addr_arr[winner];
      cap_waddr_d  = wr_addr_arr[winner];
      cap_wdata_d  = wr_data_arr[winner];
      cnt_d        = CNT_LOAD;
    end
  end

  // Control and response registers; reset drops any captured request.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
      cur_q        <= '0;
      cap_rd_q     <= 1'b0;
      cap_wr_q     <= 1'b0;
      cap_raddr_q  <= '0;
      cap_waddr_q  <= '0;
      cap_wdata_q  <= '0;
      rd_ready_q   <= '0;
      wr_ready_q   <= '0;
      rd_data_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      cur_q        <= cur_d;
      cap_rd_q     <= cap_rd_d;
      cap_wr_q     <= cap_wr_d;
      cap_raddr_q  <= cap_raddr_d;
      cap_waddr_q  <= cap_waddr_d;
      cap_wdata_q  <= cap_wdata_d;
      rd_ready_q   <= rd_ready_d;
      wr_ready_q   <= wr_ready_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Data memory write port, committed on the completion edge.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is intentionally not reset; its contents survive
    // reset and only the control path restarts.
    if (complete && cap_wr_q) mem[cap_waddr_q] <= cap_wdata_q;
  end

endmodule
